// File: rtl/sonar_pkg.sv
// Shared sonar constants and the ADC responder state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sonar_pkg;

    localparam int ADC_DATA_WIDTH      = 16;
    localparam int ADC_DATA_CLK_PERIOD = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } resp_state_t;

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall pulse outputs.
// Latency: edge pulse is high STAGES cycles after the pin is first sampled changed.
// Backpressure: none; pulses are single-cycle and must be consumed immediately.
module pin_sync_edge #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              edge_q;

    // Synchronizer chain plus one delayed copy for edge detection; resets to the pin idle level.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{IDLE_LEVEL}};
            edge_q <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            edge_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~edge_q;
    assign fall = ~sync_q[STAGES-1] & edge_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI peripheral model of the sonar ADC: serves buffered 16-bit samples MSB-first.
// Latency: data/oe change SYNC_STAGES+1 cycles after a pin edge is first sampled.
// Backpressure: single-entry hold buffer; sample_ready_out low while it is full.
module spi_adc_responder
    import sonar_pkg::*;
#(
    parameter int DATA_WIDTH  = ADC_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    output logic                  sample_ready_out,
    input  logic                  chip_sel_in,
    input  logic                  chip_clk_in,
    output logic                  chip_data_out,
    output logic                  chip_data_oe_out,
    output logic                  frame_done_out,
    output logic                  underrun_out,
    output logic                  abort_out
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic cs_rise, cs_fall;
    logic sclk_rise, sclk_fall;

    resp_state_t           state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] last_sample_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  sample_accept;

    pin_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pin    (chip_sel_in),
        .rise   (cs_rise),
        .fall   (cs_fall)
    );

    pin_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sclk_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pin    (chip_clk_in),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    assign sample_ready_out = !hold_full_q;
    assign sample_accept    = sample_valid_in && !hold_full_q;

    // Frame FSM with registered pin outputs and event pulses, plus the hold-buffer write port.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            shift_q          <= '0;
            last_sample_q    <= '0;
            hold_q           <= '0;
            hold_full_q      <= 1'b0;
            bit_cnt_q        <= '0;
            chip_data_out    <= 1'b0;
            chip_data_oe_out <= 1'b0;
            frame_done_out   <= 1'b0;
            underrun_out     <= 1'b0;
            abort_out        <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            underrun_out   <= 1'b0;
            abort_out      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q          <= SHIFT;
                        bit_cnt_q        <= '0;
                        chip_data_oe_out <= 1'b1;
                        if (hold_full_q) begin
                            shift_q       <= hold_q;
                            last_sample_q <= hold_q;
                            hold_full_q   <= 1'b0;
                            chip_data_out <= hold_q[DATA_WIDTH-1];
                        end else begin
                            // Nothing fresh: repeat the previous sample and flag it.
                            shift_q       <= last_sample_q;
                            underrun_out  <= 1'b1;
                            chip_data_out <= last_sample_q[DATA_WIDTH-1];
                        end
                    end
                end

                SHIFT: begin
                    if (cs_rise) begin
                        // Early deselect: the loaded sample is considered consumed.
                        abort_out        <= 1'b1;
                        state_q          <= IDLE;
                        chip_data_oe_out <= 1'b0;
                        chip_data_out    <= 1'b0;
                    end else if (sclk_rise) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            frame_done_out <= 1'b1;
                            state_q        <= DONE;
                            chip_data_out  <= 1'b0;
                        end
                    end else if (sclk_fall && (bit_cnt_q != '0)) begin
                        // The leading fall of an idle-high clock precedes the first sample
                        // edge; shifting then would discard the MSB before it is read.
                        shift_q       <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                        chip_data_out <= shift_q[DATA_WIDTH-2];
                    end
                end

                DONE: begin
                    if (cs_rise) begin
                        state_q          <= IDLE;
                        chip_data_oe_out <= 1'b0;
                        chip_data_out    <= 1'b0;
                    end
                end

                default: begin
                    state_q          <= IDLE;
                    chip_data_oe_out <= 1'b0;
                    chip_data_out    <= 1'b0;
                end
            endcase

            // Accept never overlaps a hold-buffer load: that load needs hold full, accept needs it empty.
            if (sample_accept) begin
                hold_q      <= sample_in;
                hold_full_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: SPI controller model plus event scoreboard.
// Latency: n/a.
// Backpressure: pushes wait (bounded) for sample_ready_out.
module tb_spi_adc_responder;
    import sonar_pkg::*;

    localparam int W    = ADC_DATA_WIDTH;
    localparam int HALF = ADC_DATA_CLK_PERIOD;

    localparam int EV_WORD  = 0;
    localparam int EV_UNDER = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ABORT = 3;

    logic         clk_100mhz = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sample_in = '0;
    logic         sample_valid_in = 1'b0;
    logic         sample_ready_out;
    logic         chip_sel_in = 1'b1;
    logic         chip_clk_in = 1'b1;
    logic         chip_data_out;
    logic         chip_data_oe_out;
    logic         frame_done_out;
    logic         underrun_out;
    logic         abort_out;

    typedef struct {
        int           kind;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cap_cnt = 0;
    int           cap_seen = 0;
    logic [W-1:0] cap_dat = '0;

    spi_adc_responder #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk_in           (clk_100mhz),
        .rst_n            (rst_n),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .chip_sel_in      (chip_sel_in),
        .chip_clk_in      (chip_clk_in),
        .chip_data_out    (chip_data_out),
        .chip_data_oe_out (chip_data_oe_out),
        .frame_done_out   (frame_done_out),
        .underrun_out     (underrun_out),
        .abort_out        (abort_out)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    task automatic expect_ev(input int kind, input logic [W-1:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check1(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, act, want);
        end
    endtask

    task automatic mon(input int kind, input logic [W-1:0] d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: got kind %0d data %h want nothing", kind, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_WORD && e.data !== d)) begin
                errors++;
                $display("FAIL event: got kind %0d data %h want kind %0d data %h",
                         kind, d, e.kind, e.data);
            end
        end
    endtask

    task automatic push(input logic [W-1:0] v);
        int guard;
        guard = 0;
        while (!sample_ready_out && guard < 50) begin
            cyc(1);
            guard++;
        end
        check1("push_ready", sample_ready_out, 1'b1);
        sample_in       = v;
        sample_valid_in = 1'b1;
        cyc(1);
        sample_valid_in = 1'b0;
    endtask

    // Drop CS and clock nbits; captured bits are reported per 16 bits or at the end.
    task automatic run_frame(input int nbits, input bit push_now, input logic [W-1:0] push_val);
        logic [W-1:0] word;
        int           n;
        chip_sel_in = 1'b0;
        if (push_now) begin
            // Valid lands on the cycle the synchronized CS fall loads the shifter.
            cyc(2);
            sample_in       = push_val;
            sample_valid_in = 1'b1;
            cyc(1);
            sample_valid_in = 1'b0;
            cyc(7);
        end else begin
            cyc(10);
        end
        check1("oe_in_frame", chip_data_oe_out, 1'b1);
        word = '0;
        n    = 0;
        for (int i = 0; i < nbits; i++) begin
            chip_clk_in = 1'b0;
            cyc(HALF);
            word        = {word[W-2:0], chip_data_out};
            chip_clk_in = 1'b1;
            n++;
            if (n == W || i == nbits - 1) begin
                cap_dat = word;
                cap_cnt++;
                word = '0;
                n    = 0;
            end
            cyc(HALF);
        end
    endtask

    task automatic end_frame();
        chip_sel_in = 1'b1;
        cyc(10);
    endtask

    initial begin
        fork
            begin
                #1000000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1, "timeout");
            end
            forever begin
                @(negedge clk_100mhz);
                if (underrun_out)   mon(EV_UNDER, '0);
                if (frame_done_out) mon(EV_DONE, '0);
                if (abort_out)      mon(EV_ABORT, '0);
                if (cap_cnt != cap_seen) begin
                    cap_seen++;
                    mon(EV_WORD, cap_dat);
                end
            end
        join_none

        // Reset state
        cyc(3);
        check1("rst_ready", sample_ready_out, 1'b1);
        check1("rst_oe", chip_data_oe_out, 1'b0);
        check1("rst_data", chip_data_out, 1'b0);
        check1("rst_done", frame_done_out, 1'b0);
        check1("rst_underrun", underrun_out, 1'b0);
        check1("rst_abort", abort_out, 1'b0);
        rst_n = 1'b1;
        cyc(3);

        // Frame with nothing pushed serves the reset value of last_sample
        expect_ev(EV_UNDER, '0); expect_ev(EV_WORD, 16'h0000); expect_ev(EV_DONE, '0);
        run_frame(16, 1'b0, '0);
        end_frame();

        // Normal frame
        push(16'hA5C3);
        check1("ready_after_push", sample_ready_out, 1'b0);
        expect_ev(EV_WORD, 16'hA5C3); expect_ev(EV_DONE, '0);
        run_frame(16, 1'b0, '0);
        end_frame();
        check1("ready_after_frame", sample_ready_out, 1'b1);

        // One push, two frames: second repeats and underruns
        push(16'h1234);
        expect_ev(EV_WORD, 16'h1234); expect_ev(EV_DONE, '0);
        run_frame(16, 1'b0, '0);
        end_frame();
        expect_ev(EV_UNDER, '0); expect_ev(EV_WORD, 16'h1234); expect_ev(EV_DONE, '0);
        run_frame(16, 1'b0, '0);
        end_frame();

        // Abort after 7 bits, then a clean frame
        push(16'hFFFF);
        expect_ev(EV_WORD, 16'h007F); expect_ev(EV_ABORT, '0);
        run_frame(7, 1'b0, '0);
        chip_sel_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            if (!chip_data_oe_out) break;
        end
        check1("oe_after_abort", chip_data_oe_out, 1'b0);
        cyc(10);
        push(16'h0F0F);
        expect_ev(EV_WORD, 16'h0F0F); expect_ev(EV_DONE, '0);
        run_frame(16, 1'b0, '0);
        end_frame();

        // Push coincident with the frame-start load while hold is empty
        expect_ev(EV_UNDER, '0); expect_ev(EV_WORD, 16'h0F0F); expect_ev(EV_DONE, '0);
        run_frame(16, 1'b1, 16'h8001);
        end_frame();
        expect_ev(EV_WORD, 16'h8001); expect_ev(EV_DONE, '0);
        run_frame(16, 1'b0, '0);
        end_frame();

        // Over-long frame: extra bits read 0, done only once
        push(16'h00FF);
        expect_ev(EV_WORD, 16'h00FF); expect_ev(EV_DONE, '0); expect_ev(EV_WORD, 16'h0000);
        run_frame(20, 1'b0, '0);
        end_frame();

        // Reset mid-frame after 8 bits
        push(16'hC3C3);
        expect_ev(EV_WORD, 16'h00C3);
        run_frame(8, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        check1("midrst_oe", chip_data_oe_out, 1'b0);
        check1("midrst_data", chip_data_out, 1'b0);
        check1("midrst_ready", sample_ready_out, 1'b1);
        check1("midrst_done", frame_done_out, 1'b0);
        chip_sel_in = 1'b1;
        chip_clk_in = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        check1("postrst_ready", sample_ready_out, 1'b1);
        expect_ev(EV_UNDER, '0); expect_ev(EV_WORD, 16'h0000); expect_ev(EV_DONE, '0);
        run_frame(16, 1'b0, '0);
        end_frame();

        cyc(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL events_missing: got %0d outstanding want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
Peripheral-side SPI model of the sonar ADC. It serves 16-bit samples to spi_con over chip_sel/chip_clk/chip_data, so the receive chain can be run on the board with ADCs disconnected, or in loopback from synthetic echo generators. It takes samples through a valid/ready port into a single-entry holding buffer. It shifts each sample out MSB-first on a frame framed by chip select. Every pin input is oversampled and synchronized into the clk_in domain.

Parameters:
DATA_WIDTH, 16, bits per frame and per sample.
SYNC_STAGES, 2, flip-flop synchronizer depth on chip_clk_in and chip_sel_in; minimum 2.

Ports:
clk_in  input  1  system clock, 100 MHz.
rst_n  input  1  reset, asynchronous, active-low.
sample_in  input  DATA_WIDTH  next sample to serve.
sample_valid_in  input  1  sample_in is valid.
sample_ready_out  output  1  holding buffer can accept a sample.
chip_sel_in  input  1  SPI chip select from the controller, active-low, asynchronous.
chip_clk_in  input  1  SPI clock from the controller, idle high, asynchronous.
chip_data_out  output  1  serial data (cipo), MSB first.
chip_data_oe_out  output  1  high while this block drives chip_data_out (frame active).
frame_done_out  output  1  one-cycle pulse when DATA_WIDTH bits have been clocked.
underrun_out  output  1  one-cycle pulse when a frame starts with the holding buffer empty.
abort_out  output  1  one-cycle pulse when chip select rises before the frame completes.

Behaviour:
- Interface decision: one clock (clk_in). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - All outputs are 0, except sample_ready_out = 1.
  - Shift register, last_sample, hold register and bit counter are 0. hold_full = 0.
  - Synchronizer flops reset to 1, which is the idle level of the pins.
- Synchronizers and edge detection:
  - Both pins pass through SYNC_STAGES flops, then one edge-detect flop.
  - An edge is detected SYNC_STAGES+1 cycles after the pin changes.
  - chip_data_out changes at most SYNC_STAGES+2 cycles after the pin edge.
  - Supported SCLK half-period is at least SYNC_STAGES+3 clk_in cycles (5 at default), which matches DATA_CLK_PERIOD=5.
- Holding buffer:
  - sample_ready_out = !hold_full.
  - When valid and ready are both high, the sample is stored and hold_full is set on the next cycle.
- State machine, states IDLE, SHIFT, DONE:
  - IDLE:
    - Synced chip select falling -> SHIFT.
    - If hold_full: load hold into the shift register and last_sample, and clear hold_full.
    - If not hold_full: load last_sample (repeat the previous sample) and pulse underrun_out.
    - Bit counter is cleared. chip_data_oe_out goes to 1, and chip_data_out = shift register MSB.
  - SHIFT:
    - Synced SCLK rising: increment the bit counter. The controller samples on this edge.
    - Synced SCLK falling: shift left by one, filling with 0, so the next bit is presented.
    - After the DATA_WIDTH-th rising edge: pulse frame_done_out -> DONE.
    - Chip select rising before that point: pulse abort_out -> IDLE. The loaded sample is treated as consumed, not re-queued.
  - DONE:
    - Drive chip_data_out = 0 and ignore further SCLK edges.
    - Chip select rising -> IDLE.
  - IDLE outputs: chip_data_out = 0 and chip_data_oe_out = 0.
- Simultaneous events:
  - Sample accept in the same cycle as a frame-start load with hold empty: underrun fires, last_sample is served, and the new sample is stored for the next frame.
  - Frame-start load with hold full in the same cycle as an accept: cannot happen, because ready was low.
- SCLK edges while chip select is high are ignored.
- Reset mid-frame: returns immediately to IDLE and releases chip_data_oe_out. Buffered data is lost.

Decomposition:
- Shared package sonar_pkg: ADC_DATA_WIDTH=16, ADC_DATA_CLK_PERIOD=5, and the responder state enum (IDLE/SHIFT/DONE).
- One natural sub-module: pin_sync_edge, an N-stage synchronizer plus rise/fall pulse outputs. It is instantiated twice, for chip_sel_in and chip_clk_in.

Test Plan:
1. Push 16'hA5C3, then run one spi_con-style frame (CS low, 16 SCLK cycles, half-period 5) -> controller captures 16'hA5C3; frame_done_out pulses once; underrun_out = 0; sample_ready_out returns to 1.
2. After reset, run a frame with no sample pushed -> underrun_out pulses at frame start; 16'h0000 is served. Push 16'h1234 then run two frames -> 16'h1234 is served twice; the second frame pulses underrun.
3. Push 16'hFFFF, then raise CS after 7 SCLK rising edges -> abort_out pulses; no frame_done_out; chip_data_oe_out = 0 within SYNC_STAGES+2 cycles. The next frame, with 16'h0F0F pushed, serves 16'h0F0F.
4. Push 16'h8001 while hold is empty, in the same cycle the synced CS-fall load occurs -> underrun pulse; the current frame returns the previous sample; the next frame returns 16'h8001.
5. Run a frame with 20 SCLK cycles for sample 16'h00FF -> the first 16 bits equal 16'h00FF; the remaining bits read 0; frame_done_out pulses after the 16th rising edge only.
6. Assert rst_n low mid-frame after 8 bits -> all outputs reach reset values asynchronously; after release, ready = 1 and the next frame underruns, serving 16'h0000.
